// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler that shares one FPU datapath between an HCI and a SIMD
// requester: launch, bounded wait for the result, and a one-cycle response.
module fpu_op_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] QNAN    = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        hci_req,
  input  logic [1:0]  hci_format,
  input  logic [1:0]  hci_operation,
  input  logic [31:0] hci_a,
  input  logic [31:0] hci_b,
  input  logic [31:0] hci_c,
  input  logic        simd_req,
  input  logic [1:0]  simd_format,
  input  logic [1:0]  simd_operation,
  input  logic [31:0] simd_a,
  input  logic [31:0] simd_b,
  input  logic [31:0] simd_c,
  output logic        hci_gnt,
  output logic        simd_gnt,
  output logic        hci_done,
  output logic        simd_done,
  output logic [31:0] res_out,
  output logic [3:0]  res_flags,
  output logic        res_timeout,
  output logic        dp_start,
  output logic [1:0]  dp_format,
  output logic [1:0]  dp_operation,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic [31:0] dp_c,
  input  logic        dp_ready,
  input  logic [31:0] dp_result,
  input  logic [3:0]  dp_flags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic       OWN_SIMD = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d, owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hci_gnt_q, hci_gnt_d, simd_gnt_q, simd_gnt_d;
  logic        hci_done_q, hci_done_d, simd_done_q, simd_done_d;
  logic        dp_start_q, dp_start_d, busy_q, busy_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        tmo_q, tmo_d;
  logic [1:0]  dp_format_q, dp_format_d, dp_operation_q, dp_operation_d;
  logic [31:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
  logic        win, grant, finish, launch;
  logic [1:0]  win_format;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    res_d          = res_q;
    flags_d        = flags_q;
    tmo_d          = tmo_q;
    dp_format_d    = dp_format_q;
    dp_operation_d = dp_operation_q;
    dp_a_d         = dp_a_q;
    dp_b_d         = dp_b_q;
    dp_c_d         = dp_c_q;
    grant          = 1'b0;
    finish         = 1'b0;
    launch         = 1'b0;
    // On a tie the requester that did not own the last operation wins.
    win            = (hci_req && simd_req) ? ~ptr_q : simd_req;
    win_format     = win ? simd_format : hci_format;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hci_req || simd_req) begin
            owner_d        = win;
            grant          = 1'b1;
            dp_format_d    = win_format;
            dp_operation_d = win ? simd_operation : hci_operation;
            dp_a_d         = win ? simd_a : hci_a;
            dp_b_d         = win ? simd_b : hci_b;
            dp_c_d         = win ? simd_c : hci_c;
            if (win_format == 2'b11) begin
              state_d = RESP;
              finish  = 1'b1;
              res_d   = QNAN;
              flags_d = 4'b1000;
              tmo_d   = 1'b0;
            end else begin
              state_d = ISSUE;
              launch  = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + 8'd1;
          // A result arriving in the final wait cycle beats the timeout.
          if (dp_ready) begin
            res_d   = dp_result;
            flags_d = dp_flags;
            tmo_d   = 1'b0;
            finish  = 1'b1;
            state_d = RESP;
          end else if (cnt_q == CNT_LAST) begin
            res_d   = QNAN;
            flags_d = 4'b1000;
            tmo_d   = 1'b1;
            finish  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
        RESP: begin
          ptr_d   = owner_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    hci_gnt_d   = grant & ~owner_d;
    simd_gnt_d  = grant & owner_d;
    hci_done_d  = finish & ~owner_d;
    simd_done_d = finish & owner_d;
    dp_start_d  = launch;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= OWN_SIMD;
      owner_q        <= 1'b0;
      cnt_q          <= 8'd0;
      hci_gnt_q      <= 1'b0;
      simd_gnt_q     <= 1'b0;
      hci_done_q     <= 1'b0;
      simd_done_q    <= 1'b0;
      dp_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      res_q          <= 32'd0;
      flags_q        <= 4'd0;
      tmo_q          <= 1'b0;
      dp_format_q    <= 2'd0;
      dp_operation_q <= 2'd0;
      dp_a_q         <= 32'd0;
      dp_b_q         <= 32'd0;
      dp_c_q         <= 32'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      hci_gnt_q      <= hci_gnt_d;
      simd_gnt_q     <= simd_gnt_d;
      hci_done_q     <= hci_done_d;
      simd_done_q    <= simd_done_d;
      dp_start_q     <= dp_start_d;
      busy_q         <= busy_d;
      res_q          <= res_d;
      flags_q        <= flags_d;
      tmo_q          <= tmo_d;
      dp_format_q    <= dp_format_d;
      dp_operation_q <= dp_operation_d;
      dp_a_q         <= dp_a_d;
      dp_b_q         <= dp_b_d;
      dp_c_q         <= dp_c_d;
    end
  end

  assign hci_gnt      = hci_gnt_q;
  assign simd_gnt     = simd_gnt_q;
  assign hci_done     = hci_done_q;
  assign simd_done    = simd_done_q;
  assign dp_start     = dp_start_q;
  assign busy         = busy_q;
  assign res_out      = res_q;
  assign res_flags    = flags_q;
  assign res_timeout  = tmo_q;
  assign dp_format    = dp_format_q;
  assign dp_operation = dp_operation_q;
  assign dp_a         = dp_a_q;
  assign dp_b         = dp_b_q;
  assign dp_c         = dp_c_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Scoreboard bench for fpu_op_scheduler: a transaction-level model predicts the
// winner, result and completion cycle of each operation; a monitor checks dones.
module tb_fpu_op_scheduler;
  localparam int          TO = 4;
  localparam logic [31:0] QN = 32'h7FC0_0000;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } op_t;

  typedef struct {
    bit          who;   // 1 = SIMD
    logic [31:0] res;
    logic [3:0]  flags;
    bit          tmo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        abort = 1'b0;
  logic        hci_req = 1'b0, simd_req = 1'b0;
  logic [1:0]  hci_format, hci_operation, simd_format, simd_operation;
  logic [31:0] hci_a, hci_b, hci_c, simd_a, simd_b, simd_c;
  logic        hci_gnt, simd_gnt, hci_done, simd_done;
  logic [31:0] res_out;
  logic [3:0]  res_flags;
  logic        res_timeout, dp_start, busy;
  logic [1:0]  dp_format, dp_operation;
  logic [31:0] dp_a, dp_b, dp_c;
  logic        dp_ready = 1'b0;
  logic [31:0] dp_result = 32'd0;
  logic [3:0]  dp_flags = 4'd0;

  op_t  h_op, s_op;
  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  bit          last_owner = 1'b1;
  logic [31:0] m_res = 32'd0;
  logic [3:0]  m_flags = 4'd0;
  bit          m_tmo = 1'b0;

  assign hci_format     = h_op.fmt;
  assign hci_operation  = h_op.op;
  assign hci_a          = h_op.a;
  assign hci_b          = h_op.b;
  assign hci_c          = h_op.c;
  assign simd_format    = s_op.fmt;
  assign simd_operation = s_op.op;
  assign simd_a         = s_op.a;
  assign simd_b         = s_op.b;
  assign simd_c         = s_op.c;

  fpu_op_scheduler #(.TIMEOUT(TO), .QNAN(QN)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .hci_req(hci_req), .hci_format(hci_format), .hci_operation(hci_operation),
    .hci_a(hci_a), .hci_b(hci_b), .hci_c(hci_c),
    .simd_req(simd_req), .simd_format(simd_format), .simd_operation(simd_operation),
    .simd_a(simd_a), .simd_b(simd_b), .simd_c(simd_c),
    .hci_gnt(hci_gnt), .simd_gnt(simd_gnt), .hci_done(hci_done), .simd_done(simd_done),
    .res_out(res_out), .res_flags(res_flags), .res_timeout(res_timeout),
    .dp_start(dp_start), .dp_format(dp_format), .dp_operation(dp_operation),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_ready(dp_ready), .dp_result(dp_result), .dp_flags(dp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic op_t rand_op(input bit allow_rej);
    op_t o;
    o.fmt = allow_rej ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    o.op  = 2'($urandom_range(0, 3));
    o.a   = $urandom;
    o.b   = $urandom;
    o.c   = $urandom;
    return o;
  endfunction

  // Monitor: every done pulse must match the oldest predicted completion.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (hci_done || simd_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected done", {hci_done, simd_done}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("done owner", {hci_done, simd_done}, e.who ? 2'b01 : 2'b10);
        chk("done cycle", cyc, e.cyc);
        chk("res_out", res_out, e.res);
        chk("res_flags", res_flags, e.flags);
        chk("res_timeout", res_timeout, e.tmo);
      end
    end
  end

  // Raise requests in an IDLE cycle, optionally predict the completion, and check the grant.
  task automatic launch(input bit hr, input bit sr, input int delay, input bit push,
                        input logic [31:0] val, input logic [3:0] fl,
                        output bit win, output int n);
    op_t  w;
    exp_t e;
    bit   got;
    win = (hr && sr) ? ~last_owner : sr;
    w   = win ? s_op : h_op;
    n   = cyc;
    hci_req  = hr;
    simd_req = sr;
    if (push) begin
      e.who = win;
      e.tmo = 1'b0;
      if (w.fmt == 2'b11) begin
        e.res = QN; e.flags = 4'b1000; e.cyc = n + 1;
      end else if (delay <= TO) begin
        e.res = val; e.flags = fl; e.cyc = n + 2 + delay;
      end else begin
        e.res = QN; e.flags = 4'b1000; e.tmo = 1'b1; e.cyc = n + 2 + TO;
      end
      sb.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      dp_ready = 1'b0;
      if (hci_gnt || simd_gnt) got = 1'b1;
    end
    chk("gnt seen", got, 1'b1);
    if (got) begin
      chk("gnt cycle", cyc, n + 1);
      chk("gnt owner", {hci_gnt, simd_gnt}, win ? 2'b01 : 2'b10);
      chk("dp_start at gnt", dp_start, w.fmt != 2'b11);
      chk("busy at gnt", busy, 1'b1);
      chk("dp operands", {dp_format, dp_operation, dp_a, dp_b, dp_c}, w);
    end
    if (win) simd_req = 1'b0;
    else hci_req = 1'b0;
  endtask

  // One complete operation; returns in the IDLE cycle that follows its done.
  task automatic serve(input bit hr, input bit sr, input int delay,
                       input logic [31:0] val, input logic [3:0] fl);
    bit win;
    int n, dcyc;
    op_t w;
    launch(hr, sr, delay, 1'b1, val, fl, win, n);
    w = win ? s_op : h_op;
    if (w.fmt == 2'b11) begin
      dcyc = n + 1;
      m_res = QN; m_flags = 4'b1000; m_tmo = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("dp_start one cycle", dp_start, 1'b0);
      while (cyc < n + 1 + delay) begin @(posedge clk); #1; end
      dp_ready = 1'b1; dp_result = val; dp_flags = fl;
      @(posedge clk); #1;
      dp_ready = 1'b0; dp_result = $urandom; dp_flags = 4'($urandom);
      if (delay <= TO) begin
        dcyc = n + 2 + delay; m_res = val; m_flags = fl; m_tmo = 1'b0;
      end else begin
        dcyc = n + 2 + TO; m_res = QN; m_flags = 4'b1000; m_tmo = 1'b1;
      end
    end
    while (cyc < dcyc + 1) begin @(posedge clk); #1; end
    chk("busy after done", busy, 1'b0);
    chk("result held", {res_out, res_flags, res_timeout}, {m_res, m_flags, m_tmo});
    last_owner = win;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        win;
    int        n;
    bit [1:0]  sel;
    h_op = '0;
    s_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", {hci_gnt, simd_gnt, hci_done, simd_done, dp_start, busy,
                      res_flags, res_timeout, dp_format, dp_operation}, '0);
    chk("reset data", {res_out, dp_a, dp_b, dp_c}, '0);
    reset = 1'b0;

    // single HCI add
    h_op = '{fmt: 2'b00, op: 2'b00, a: 32'h3F80_0000, b: 32'h4000_0000, c: 32'd0};
    serve(1'b1, 1'b0, 2, 32'h4040_0000, 4'b0000);

    // tie out of reset pointer history: HCI then SIMD, then HCI wins again
    h_op = rand_op(1'b0); s_op = rand_op(1'b0);
    serve(1'b1, 1'b1, 1, $urandom, 4'($urandom));
    serve(1'b0, 1'b1, 3, $urandom, 4'($urandom));
    serve(1'b1, 1'b1, 2, $urandom, 4'($urandom));
    serve(1'b0, 1'b1, 2, $urandom, 4'($urandom));
    serve(1'b1, 1'b0, 1, $urandom, 4'($urandom));
    serve(1'b1, 1'b1, 1, $urandom, 4'($urandom));
    serve(1'b1, 1'b0, 1, $urandom, 4'($urandom));

    // timeout, with a late dp_ready landing in RESP
    h_op = rand_op(1'b0);
    serve(1'b1, 1'b0, TO + 1, $urandom, 4'($urandom));
    // dp_ready in the last wait cycle beats the timeout
    s_op = rand_op(1'b0);
    serve(1'b0, 1'b1, TO, 32'h1234_5678, 4'b0011);
    // format reject
    s_op = rand_op(1'b0); s_op.fmt = 2'b11;
    serve(1'b0, 1'b1, 1, $urandom, 4'($urandom));

    // abort in WAIT; dp_ready after it is ignored; pending SIMD is served afresh
    h_op = rand_op(1'b0); s_op = rand_op(1'b0);
    launch(1'b1, 1'b0, 2, 1'b0, 32'd0, 4'd0, win, n);
    simd_req = 1'b1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; dp_ready = 1'b1; dp_result = $urandom; dp_flags = 4'hF;
    chk("busy after abort", busy, 1'b0);
    chk("res held over abort", {res_out, res_flags, res_timeout}, {m_res, m_flags, m_tmo});
    serve(1'b0, 1'b1, 3, $urandom, 4'($urandom));
    serve(1'b1, 1'b0, 2, $urandom, 4'($urandom));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel  = 2'($urandom_range(1, 3));
      h_op = rand_op(($urandom_range(0, 3) == 0));
      s_op = rand_op(($urandom_range(0, 3) == 0));
      serve(sel[0], sel[1], $urandom_range(1, TO + 1), $urandom, 4'($urandom));
    end

    // asynchronous reset in WAIT abandons the operation
    h_op = rand_op(1'b0);
    launch(1'b1, 1'b0, 3, 1'b0, 32'd0, 4'd0, win, n);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("async reset ctl", {hci_gnt, simd_gnt, hci_done, simd_done, dp_start, busy,
                            res_flags, res_timeout, dp_format, dp_operation}, '0);
    chk("async reset data", {res_out, dp_a, dp_b, dp_c}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_owner = 1'b1; m_res = 32'd0; m_flags = 4'd0; m_tmo = 1'b0;
    h_op = rand_op(1'b0); s_op = rand_op(1'b0);
    serve(1'b1, 1'b1, 2, $urandom, 4'($urandom));
    serve(1'b0, 1'b1, 1, $urandom, 4'($urandom));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
